load_store_unit: RTL and testbench

Memory-side load/store unit for the RV32I core. It accepts one load or store request at a time from the execute stage and drives the word-organised zero-delay data RAM. It performs byte and halfword accesses: loads use lane extraction with sign or zero extension, and sub-word stores use a read-modify-write sequence. It returns one response per request and flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings and FSM state type for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend, store merge and legality check
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic [dataW-1:0] word,
  input  logic [1:0]       addr,
  input  logic [2:0]       funct3,
  input  logic             write,
  input  logic [dataW-1:0] wdata,
  output logic [dataW-1:0] load_data,
  output logic [dataW-1:0] store_word,
  output logic             err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = word[{addr, 3'b000} +: 8];
    half_lane  = word[{addr[1], 4'b0000} +: 16];
    load_data  = '0;
    store_word = word;
    err        = 1'b1;
    case (funct3)
      F3_B: begin
        load_data = {{24{byte_lane[7]}}, byte_lane};
        store_word[{addr, 3'b000} +: 8] = wdata[7:0];
        err = 1'b0;
      end
      F3_H: begin
        load_data = {{16{half_lane[15]}}, half_lane};
        store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        err = addr[0];
      end
      F3_W: begin
        load_data  = word;
        store_word = wdata;
        err = (addr != 2'b00);
      end
      // unsigned variants exist only for loads
      F3_BU: begin
        load_data = {24'b0, byte_lane};
        err = write;
      end
      F3_HU: begin
        load_data = {16'b0, half_lane};
        err = write | addr[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store FSM driving a zero-delay word RAM
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [RAMAddrSize-1:0] req_addr,
  input  logic [dataW-1:0]       req_wdata,
  output logic                   resp_valid,
  output logic [dataW-1:0]       resp_rdata,
  output logic                   resp_err,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       RAMDataOut,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMIn
);

  lsu_state_t state, next_state;

  logic                   write_q;
  logic [2:0]             f3_q;
  logic [RAMAddrSize-1:0] addr_q;
  logic [dataW-1:0]       wdata_q;
  logic [dataW-1:0]       word_q;

  logic             idle, accept;
  logic             sel_write;
  logic [2:0]       sel_f3;
  logic [1:0]       sel_addr;
  logic [dataW-1:0] sel_wdata, sel_word;
  logic [dataW-1:0] load_data, store_word;
  logic             lane_err;

  assign idle      = (state == IDLE);
  assign req_ready = idle && !reset;
  assign accept    = req_valid && req_ready;

  // In IDLE the lane logic checks the incoming request; afterwards it works on the latched one.
  assign sel_write = idle ? req_write        : write_q;
  assign sel_f3    = idle ? req_funct3       : f3_q;
  assign sel_addr  = idle ? req_addr[1:0]    : addr_q[1:0];
  assign sel_wdata = idle ? req_wdata        : wdata_q;
  assign sel_word  = (state == READ) ? RAMIn : word_q;

  lsu_lane_align #(.dataW(dataW)) u_lane (
    .word       (sel_word),
    .addr       (sel_addr),
    .funct3     (sel_f3),
    .write      (sel_write),
    .wdata      (sel_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .err        (lane_err)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (lane_err)                         next_state = RESP;
          else if (req_write && req_funct3 == F3_W) next_state = WRITE;
          else                                  next_state = READ;
        end
      end
      READ:    next_state = write_q ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ) word_q <= RAMIn;
      resp_valid <= (next_state == RESP);
      resp_err   <= idle && (next_state == RESP);
      resp_rdata <= (state == READ && next_state == RESP) ? load_data : '0;
    end
  end

  always_comb begin
    RAMAddr         = '0;
    RAMDataOut      = '0;
    RAMWriteControl = 1'b0;
    if (!reset && (state == READ || state == WRITE))
      RAMAddr = {addr_q[RAMAddrSize-1:2], 2'b00};
    if (!reset && state == WRITE) begin
      RAMDataOut      = store_word;
      RAMWriteControl = 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a reference model
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  RAMAddr;
  logic [31:0] RAMDataOut;
  logic        RAMWriteControl;
  logic [31:0] RAMIn;

  int checks = 0;
  int failures = 0;

  logic [31:0] dram [64];
  logic [31:0] ref_mem [64];

  always #5 clock = ~clock;

  load_store_unit #(.dataW(32), .RAMAddrSize(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .RAMAddr(RAMAddr), .RAMDataOut(RAMDataOut), .RAMWriteControl(RAMWriteControl),
    .RAMIn(RAMIn)
  );

  assign RAMIn = dram[RAMAddr[7:2]];
  always @(posedge clock) if (RAMWriteControl) dram[RAMAddr[7:2]] <= RAMDataOut;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one request: legality, latency, load value, memory update.
  task automatic model(input bit w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                       output bit err, output int lat, output logic [31:0] rd, output int nw);
    logic [31:0] word, mask;
    logic [7:0]  b;
    logic [15:0] h;
    int          bsh, hsh;
    bit          legal;
    word = ref_mem[a[7:2]];
    bsh  = int'(a[1:0]) * 8;
    hsh  = int'(a[1]) * 16;
    b    = 8'((word >> bsh) & 32'hFF);
    h    = 16'((word >> hsh) & 32'hFFFF);
    if (w) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) legal = 0;
    if (f3 == 3'd2 && a[1:0] != 2'b00) legal = 0;
    err = !legal;
    rd  = 32'h0;
    nw  = 0;
    if (!legal) lat = 1;
    else if (!w) begin
      lat = 2;
      case (f3)
        3'd0: rd = {{24{b[7]}}, b};
        3'd1: rd = {{16{h[15]}}, h};
        3'd2: rd = word;
        3'd4: rd = {24'h0, b};
        default: rd = {16'h0, h};
      endcase
    end else begin
      nw = 1;
      if (f3 == 3'd2) begin
        lat = 2;
        ref_mem[a[7:2]] = wd;
      end else begin
        lat = 3;
        if (f3 == 3'd0) begin
          mask = 32'hFF << bsh;
          ref_mem[a[7:2]] = (word & ~mask) | ((wd & 32'hFF) << bsh);
        end else begin
          mask = 32'hFFFF << hsh;
          ref_mem[a[7:2]] = (word & ~mask) | ((wd & 32'hFFFF) << hsh);
        end
      end
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clock);
    while (!req_ready && g < 20) begin
      @(negedge clock);
      g++;
    end
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input bit w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_obs, output logic err_obs);
    bit          e_err;
    int          e_lat, e_nw, cyc, nw;
    logic [31:0] e_rd;
    bit          got;
    model(w, f3, a, wd, e_err, e_lat, e_rd, e_nw);
    wait_ready();
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; nw = 0; got = 0; rd_obs = 'x; err_obs = 1'bx;
    while (!got && cyc < 10) begin
      @(negedge clock);
      cyc++;
      req_valid = 0;
      if (RAMWriteControl) begin
        nw++;
        chk("write_addr", {24'h0, RAMAddr}, {24'h0, a[7:2], 2'b00});
      end
      if (resp_valid) begin
        got = 1;
        rd_obs = resp_rdata;
        err_obs = resp_err;
        chk("ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
    chk("latency", got ? cyc : -1, e_lat);
    chk("rdata", rd_obs, e_rd);
    chk("err", 32'(err_obs), 32'(e_err));
    chk("write_pulses", nw, e_nw);
    chk("mem_word", dram[a[7:2]], ref_mem[a[7:2]]);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n, c, c1;
    logic [31:0] first_rd, second_rd;

    for (int i = 0; i < 64; i++) begin
      dram[i] = $urandom;
      ref_mem[i] = dram[i];
    end

    // reset state
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_ramaddr", 32'(RAMAddr), 0);
    chk("rst_dataout", RAMDataOut, 0);
    chk("rst_we", 32'(RAMWriteControl), 0);
    @(negedge clock);
    reset = 0;
    #1 chk("ready_after_reset", 32'(req_ready), 1);

    // directed sequence
    run_req(1, 3'b010, 8'h40, 32'h87654321, rd, er);
    run_req(0, 3'b010, 8'h40, 0, rd, er); chk("lw40", rd, 32'h87654321);
    run_req(0, 3'b000, 8'h43, 0, rd, er); chk("lb43", rd, 32'hFFFFFF87);
    run_req(0, 3'b100, 8'h43, 0, rd, er); chk("lbu43", rd, 32'h00000087);
    run_req(0, 3'b001, 8'h42, 0, rd, er); chk("lh42", rd, 32'hFFFF8765);
    run_req(0, 3'b101, 8'h40, 0, rd, er); chk("lhu40", rd, 32'h00004321);
    run_req(1, 3'b000, 8'h41, 32'hAA, rd, er); chk("sb41_word", dram[16], 32'h8765AA21);
    run_req(1, 3'b001, 8'h42, 32'h1234, rd, er); chk("sh42_word", dram[16], 32'h1234AA21);
    run_req(0, 3'b010, 8'h42, 0, rd, er); chk("lw42_err", 32'(er), 1);
    run_req(1, 3'b001, 8'h41, 32'hBEEF, rd, er); chk("sh41_err", 32'(er), 1);
    run_req(0, 3'b011, 8'h40, 0, rd, er); chk("f3_011_err", 32'(er), 1);
    chk("word_after_errs", dram[16], 32'h1234AA21);

    // reset during the WRITE cycle of SB 0x40 <- 0x55
    wait_ready();
    req_valid = 1; req_write = 1; req_funct3 = 3'b000; req_addr = 8'h40; req_wdata = 32'h55;
    @(negedge clock);
    req_valid = 0;
    chk("sb_read_no_we", 32'(RAMWriteControl), 0);
    @(negedge clock);
    chk("sb_write_we", 32'(RAMWriteControl), 1);
    reset = 1;
    #1 chk("reset_masks_we", 32'(RAMWriteControl), 0);
    @(negedge clock);
    chk("reset_no_resp", 32'(resp_valid), 0);
    reset = 0;
    #1 chk("ready_after_release", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("no_resp_after_reset", 32'(resp_valid), 0);
    end
    chk("word_kept", dram[16], 32'h1234AA21);

    // req_valid held across two requests
    wait_ready();
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 8'h40;
    n = 0; c = 0; c1 = 0; first_rd = 'x; second_rd = 'x;
    while (n < 2 && c < 20) begin
      @(negedge clock);
      c++;
      if (resp_valid) begin
        n++;
        if (n == 1) begin
          first_rd = resp_rdata; c1 = c;
          req_funct3 = 3'b100; req_addr = 8'h41;
        end else begin
          second_rd = resp_rdata;
        end
      end
    end
    req_valid = 0;
    chk("held_first", first_rd, 32'h1234AA21);
    chk("held_second", second_rd, 32'h000000AA);
    chk("held_gap", c - c1, 3);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f3;
      logic [7:0]  a;
      logic [31:0] wd;
      bit          w;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'hFC | 8'($urandom_range(0, 3));
      wd = $urandom;
      run_req(w, f3, a, wd, rd, er);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", dram[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
